// File: rtl/uart_rx_controller.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_controller
// Purpose  : Receive-side UART sequencer. It tracks a start / DATA_BITS data
//            (LSB first) / parity / stop frame on RxD using the 16x
//            oversampling strobe from the baud generator. It delivers each
//            good word with a one-clock valid pulse, and raises sticky parity
//            and framing error flags.
// Ports    : clk            - system clock, rising edge
//            reset          - synchronous active-high reset
//            sample_ENABLE  - one-clock oversampling strobe (OVERSAMPLE/bit)
//            Rx_EN          - receiver enable; dropping it aborts a frame
//            RxD            - asynchronous serial input, idle high
//            Rx_DATA        - last correctly received word
//            Rx_VALID       - one-clock pulse when Rx_DATA is reloaded
//            Rx_PERROR      - sticky parity error
//            Rx_FERROR      - sticky framing error
//            Rx_BUSY        - high whenever a frame is being tracked
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_controller #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_ENABLE,
    input  logic                 Rx_EN,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR,
    output logic                 Rx_BUSY
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    localparam logic [3:0] c_S_MID    = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] c_S_LAST   = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] c_BIT_LAST = 3'(DATA_BITS - 1);
    localparam logic       c_PAR_ODD  = (PARITY_ODD != 0);

    // Two-flop synchronizer for the asynchronous line.
    logic r_rxd_meta;
    logic r_rxd_s;

    logic [2:0]           r_state;
    logic [3:0]           r_s_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perror;
    logic                 r_ferror;

    logic [2:0]           w_state_nxt;
    logic [3:0]           w_s_cnt_nxt;
    logic [2:0]           w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_parity_nxt;
    logic [DATA_BITS-1:0] w_data_nxt;
    logic                 w_valid_nxt;
    logic                 w_perror_nxt;
    logic                 w_ferror_nxt;

    logic w_par_err;
    logic w_frm_err;

    // Frame checks, evaluated on the stop-bit sample tick.
    assign w_par_err = (((^r_shift) ^ r_parity) != c_PAR_ODD);
    assign w_frm_err = ~r_rxd_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= RxD;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_s_cnt   <= 4'd0;
            r_bit_cnt <= 3'd0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perror  <= 1'b0;
            r_ferror  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_s_cnt   <= w_s_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_parity  <= w_parity_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_perror  <= w_perror_nxt;
            r_ferror  <= w_ferror_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_s_cnt_nxt   = r_s_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_parity_nxt  = r_parity;
        w_data_nxt    = r_data;
        w_valid_nxt   = 1'b0;
        w_perror_nxt  = r_perror;
        w_ferror_nxt  = r_ferror;

        if ((r_state != c_IDLE) && !Rx_EN) begin
            // Abort does not wait for a tick; the partial frame is dropped.
            w_state_nxt   = c_IDLE;
            w_s_cnt_nxt   = 4'd0;
            w_bit_cnt_nxt = 3'd0;
        end else if (sample_ENABLE) begin
            case (r_state)
                c_IDLE: begin
                    if (Rx_EN && !r_rxd_s) begin
                        w_state_nxt = c_START;
                        w_s_cnt_nxt = 4'd0;
                    end
                end
                c_START: begin
                    if (r_s_cnt == c_S_MID) begin
                        w_s_cnt_nxt = 4'd0;
                        if (r_rxd_s) begin
                            w_state_nxt = c_IDLE;
                        end else begin
                            // The flags are cleared only once the start bit is
                            // confirmed. A frame with a low stop bit leaves the
                            // line low after the FSM is back in IDLE. That
                            // re-triggers a (false) start, which must not wipe
                            // the framing error it has just raised.
                            w_state_nxt   = c_DATA;
                            w_bit_cnt_nxt = 3'd0;
                            w_perror_nxt  = 1'b0;
                            w_ferror_nxt  = 1'b0;
                        end
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 4'd1;
                    end
                end
                c_DATA: begin
                    if (r_s_cnt == c_S_LAST) begin
                        w_shift_nxt   = {r_rxd_s, r_shift[DATA_BITS-1:1]};
                        w_s_cnt_nxt   = 4'd0;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            w_state_nxt = c_PARITY;
                        end
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 4'd1;
                    end
                end
                c_PARITY: begin
                    if (r_s_cnt == c_S_LAST) begin
                        w_parity_nxt = r_rxd_s;
                        w_s_cnt_nxt  = 4'd0;
                        w_state_nxt  = c_STOP;
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 4'd1;
                    end
                end
                c_STOP: begin
                    if (r_s_cnt == c_S_LAST) begin
                        // Leave mid stop bit so an immediately following start
                        // edge is seen.
                        w_s_cnt_nxt = 4'd0;
                        w_state_nxt = c_IDLE;
                        if (!w_par_err && !w_frm_err) begin
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_perror_nxt = r_perror | w_par_err;
                            w_ferror_nxt = r_ferror | w_frm_err;
                        end
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_s_cnt_nxt = 4'd0;
                end
            endcase
        end
    end

    assign Rx_DATA   = r_data;
    assign Rx_VALID  = r_valid;
    assign Rx_PERROR = r_perror;
    assign Rx_FERROR = r_ferror;
    assign Rx_BUSY   = (r_state != c_IDLE);

endmodule
`default_nettype wire
